mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables, plus the 2-bit ALU operation class that the downstream ALU decoder expands with funct. It sits between the instruction register opcode field and the datapath/memory, and stalls on a memory-ready handshake.

Parameters:
- RESET_STATE_FETCH, 1, reserved for future boot states; only the value 1 is legal.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, asynchronous active-high reset.
- opcode, input, 6, instr[31:26] from the instruction register; valid from DECODE onward.
- zero, input, 1, ALU zero flag; sampled in BRANCH.
- mem_ready, input, 1, memory completes the current access this cycle.
- mem_req, output, 1, memory access active (FETCH, MEMRD, MEMWR).
- mem_write, output, 1, the access is a write (MEMWR only).
- iord, output, 1, address select: 0 = PC, 1 = ALUOut.
- ir_write, output, 1, latch instruction (FETCH and mem_ready).
- reg_dst, output, 1, 1 = rd, 0 = rt.
- mem_to_reg, output, 1, 1 = MDR, 0 = ALUOut.
- reg_write, output, 1, register file write enable.
- alu_src_a, output, 1, 0 = PC, 1 = A.
- alu_src_b, output, 2, 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- alu_op, output, 2, 00 = add, 01 = subtract, 10 = decode funct.
- pc_src, output, 2, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en, output, 1, PC load enable (pc_write, or branch taken).
- instr_done, output, 1, one-cycle pulse on the last state of each instruction.
- illegal_op, output, 1, sticky flag for an unsupported opcode; cleared only by rst.

Behaviour:
- State register is 4 bits. Outputs are Moore-decoded from state, except that pc_en and ir_write also use zero and mem_ready.
- Reset: the state goes to FETCH asynchronously and illegal_op = 0. Outputs then take the FETCH values: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00. ir_write and pc_en equal mem_ready. All other outputs are 0.
- FETCH: hold while mem_ready = 0. When mem_ready = 1, assert ir_write and pc_en (PC+4), then go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Dispatch on opcode:
  - 000000 to EXECUTE
  - 100011 or 101011 to MEMADR
  - 000100 to BRANCH
  - 001000 to ADDIEX
  - 000010 to JUMP
  - anything else: set illegal_op, pulse instr_done, return to FETCH
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. Go to FETCH.
- MEMWR: mem_req = 1, mem_write = 1, iord = 1. Hold until mem_ready, then pulse instr_done on the completing cycle and go to FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Go to ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1. Go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01. pc_en = zero. instr_done = 1. Go to FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1. Go to FETCH.
- JUMP: pc_src = 10, pc_en = 1, instr_done = 1. Go to FETCH.
- Latencies with mem_ready always 1: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each mem_ready = 0 cycle adds one cycle.
- Any unused state encoding goes to FETCH on the next edge.
- rst asserted mid-instruction aborts it. No writes occur after rst and no instr_done pulses.

Optional Feature:
- BNE_EN:
  - Defined: opcode 000101 goes to BRANCH, where pc_en = ~zero.
  - Undefined: 000101 is illegal (illegal_op set, back to FETCH).

Decomposition:
- Package mips_ctrl_pkg holds the state enum, opcode localparams, and the alu_op, alu_src_b and pc_src encodings.
- One natural sub-module, mips_ctrl_outdec: a purely combinational map from state to control word. The FSM keeps only next-state logic and the illegal_op flag.

Test Plan:
- R-type (opcode 0x00), mem_ready = 1 → states FETCH, DECODE, EXECUTE, ALUWB. Cycle 3 has alu_op = 10. Cycle 4 has reg_write = 1, reg_dst = 1, instr_done = 1.
- lw (0x23) with mem_ready low for 2 cycles in MEMRD → 7 cycles total. MEMRD holds mem_req = 1, iord = 1. MEMWB has mem_to_reg = 1.
- beq (0x04): zero = 1 gives pc_en = 1 with pc_src = 01 in BRANCH; zero = 0 gives pc_en = 0. Total 3 cycles.
- Opcode 0x3F → illegal_op rises after DECODE and stays 1 across a following valid addi. Only rst clears it.
- rst pulsed during MEMWR → immediately in FETCH with mem_write = 0. No instr_done pulse, and mem_req = 1 on the following cycle.
- Opcode 0x05 with zero = 0: with BNE_EN, pc_en = 1 in BRANCH; without BNE_EN, illegal_op = 1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS main controller: state encoding,
// opcodes, datapath select encodings and the control word. Honours `BNE_EN.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} alu_src_b_t;
  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10} pc_src_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_src_t    pc_src;
    logic       pc_en;
    logic       instr_done;
  } ctrl_t;

  // Successor of DECODE; S_FETCH signals an unsupported opcode.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:     dispatch = S_EXECUTE;
      OP_LW, OP_SW: dispatch = S_MEMADR;
      OP_BEQ:       dispatch = S_BRANCH;
`ifdef BNE_EN
      OP_BNE:       dispatch = S_BRANCH;
`endif
      OP_ADDI:      dispatch = S_ADDIEX;
      OP_J:         dispatch = S_JUMP;
      default:      dispatch = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: opcode, flags, handshake and control word.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, instr_done, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, instr_done, illegal_op
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control word map; mem_ready and the branch decision
// are the only non-state inputs.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   branch_take,
  output ctrl_t  cw
);
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req   = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.ir_write  = mem_ready;
        cw.pc_en     = mem_ready;
      end
      S_DECODE:  cw.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req    = 1'b1;
        cw.mem_write  = 1'b1;
        cw.iord       = 1'b1;
        cw.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        cw.reg_write  = 1'b1;
        cw.reg_dst    = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a  = 1'b1;
        cw.alu_op     = ALU_SUB;
        cw.pc_src     = PC_ALUOUT;
        cw.pc_en      = branch_take;
        cw.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_JUMP: begin
        cw.pc_src     = PC_JUMP;
        cw.pc_en      = 1'b1;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath. Define BNE_EN to accept
// bne (opcode 000101) as a branch on ~zero; otherwise it is illegal.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_multicycle_ctrl_if.master bus
);
  localparam state_t RST_STATE = (RESET_STATE_FETCH == 1) ? S_FETCH : S_FETCH;

  state_t state;
  logic   illegal_q;
  logic   dec_illegal;
  logic   branch_take;
  ctrl_t  cw;

  assign dec_illegal = (state == S_DECODE) && (dispatch(bus.opcode) == S_FETCH);

`ifdef BNE_EN
  assign branch_take = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
  assign branch_take = bus.zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_STATE;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:   if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          state <= dispatch(bus.opcode);
          if (dec_illegal) illegal_q <= 1'b1;
        end
        S_MEMADR:  state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (bus.mem_ready) state <= S_FETCH;
        S_EXECUTE: state <= S_ALUWB;
        S_ADDIEX:  state <= S_ADDIWB;
        // Writeback/branch/jump states and any unused encoding return to FETCH.
        default:   state <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_outdec u_outdec (
    .state      (state),
    .mem_ready  (bus.mem_ready),
    .branch_take(branch_take),
    .cw         (cw)
  );

  assign bus.mem_req    = cw.mem_req;
  assign bus.mem_write  = cw.mem_write;
  assign bus.iord       = cw.iord;
  assign bus.ir_write   = cw.ir_write;
  assign bus.reg_dst    = cw.reg_dst;
  assign bus.mem_to_reg = cw.mem_to_reg;
  assign bus.reg_write  = cw.reg_write;
  assign bus.alu_src_a  = cw.alu_src_a;
  assign bus.alu_src_b  = cw.alu_src_b;
  assign bus.alu_op     = cw.alu_op;
  assign bus.pc_src     = cw.pc_src;
  assign bus.pc_en      = cw.pc_en;
  assign bus.instr_done = cw.instr_done | dec_illegal;
  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: cycle-by-cycle vector table
// through a scoreboard, then reset-abort and latency sequences.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();
  mips_multicycle_ctrl #(.RESET_STATE_FETCH(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Observed word: mem_req mem_write iord ir_write reg_dst mem_to_reg reg_write
  // alu_src_a alu_src_b[2] alu_op[2] pc_src[2] pc_en instr_done illegal_op
  localparam logic [16:0] W_FETCH  = 17'b1_0_0_0_0_0_0_0_01_00_00_0_0_0;
  localparam logic [16:0] W_DECODE = 17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0;
  localparam logic [16:0] W_MEMADR = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
  localparam logic [16:0] W_MEMRD  = 17'b1_0_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] W_MEMWB  = 17'b0_0_0_0_0_1_1_0_00_00_00_0_1_0;
  localparam logic [16:0] W_MEMWR  = 17'b1_1_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] W_EXEC   = 17'b0_0_0_0_0_0_0_1_00_10_00_0_0_0;
  localparam logic [16:0] W_ALUWB  = 17'b0_0_0_0_1_0_1_0_00_00_00_0_1_0;
  localparam logic [16:0] W_BRANCH = 17'b0_0_0_0_0_0_0_1_00_01_01_0_1_0;
  localparam logic [16:0] W_ADDIWB = 17'b0_0_0_0_0_0_1_0_00_00_00_0_1_0;
  localparam logic [16:0] W_JUMP   = 17'b0_0_0_0_0_0_0_0_00_00_10_1_1_0;
  localparam logic [16:0] IRW  = 17'd1 << 13;
  localparam logic [16:0] PCE  = 17'd1 << 2;
  localparam logic [16:0] DONE = 17'd1 << 1;
  localparam logic [16:0] ILL  = 17'd1;
  localparam logic [16:0] W_FETCH_GO = W_FETCH | IRW | PCE;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [16:0] observed();
    return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.pc_en, bus.instr_done, bus.illegal_op};
  endfunction

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input logic [16:0] exp, input string name);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.mr = mr; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
    rst = r; bus.opcode = op; bus.zero = z; bus.mem_ready = mr;
  endtask

  // Cycles from FETCH until instr_done, mem_ready held high; bounded at 20.
  task automatic measure(input logic [5:0] op, input int expn, input string name);
    int   n = 0;
    logic done = 1'b0;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
      drive(1'b0, op, 1'b1, 1'b1);
      #2 done = bus.instr_done;
    end
    checks++;
    if (!done || n != expn) begin
      errors++;
      $display("FAIL latency_%s: got %0d cycles (done=%0b) want %0d", name, n, done, expn);
    end
  endtask

  initial begin
    drive(1'b1, 6'h00, 1'b0, 1'b0);
    add(1, 6'h00, 0, 0, W_FETCH,    "reset_mr0");
    add(1, 6'h00, 0, 1, W_FETCH_GO, "reset_mr1");
    add(0, 6'h00, 0, 1, W_FETCH_GO, "r_fetch");
    add(0, 6'h00, 0, 1, W_DECODE,   "r_decode");
    add(0, 6'h00, 0, 1, W_EXEC,     "r_execute");
    add(0, 6'h00, 0, 1, W_ALUWB,    "r_aluwb");
    add(0, 6'h23, 0, 1, W_FETCH_GO, "lw_fetch");
    add(0, 6'h23, 0, 1, W_DECODE,   "lw_decode");
    add(0, 6'h23, 0, 1, W_MEMADR,   "lw_memadr");
    add(0, 6'h23, 0, 0, W_MEMRD,    "lw_memrd_wait1");
    add(0, 6'h23, 0, 0, W_MEMRD,    "lw_memrd_wait2");
    add(0, 6'h23, 0, 1, W_MEMRD,    "lw_memrd_done");
    add(0, 6'h23, 0, 1, W_MEMWB,    "lw_memwb");
    add(0, 6'h2B, 0, 1, W_FETCH_GO, "sw_fetch");
    add(0, 6'h2B, 0, 1, W_DECODE,   "sw_decode");
    add(0, 6'h2B, 0, 1, W_MEMADR,   "sw_memadr");
    add(0, 6'h2B, 0, 0, W_MEMWR,    "sw_memwr_wait");
    add(0, 6'h2B, 0, 1, W_MEMWR | DONE, "sw_memwr_done");
    add(0, 6'h04, 1, 1, W_FETCH_GO, "beq1_fetch");
    add(0, 6'h04, 1, 1, W_DECODE,   "beq1_decode");
    add(0, 6'h04, 1, 1, W_BRANCH | PCE, "beq_taken");
    add(0, 6'h04, 0, 1, W_FETCH_GO, "beq0_fetch");
    add(0, 6'h04, 0, 1, W_DECODE,   "beq0_decode");
    add(0, 6'h04, 0, 1, W_BRANCH,   "beq_not_taken");
    add(0, 6'h02, 0, 1, W_FETCH_GO, "j_fetch");
    add(0, 6'h02, 0, 1, W_DECODE,   "j_decode");
    add(0, 6'h02, 0, 1, W_JUMP,     "j_jump");
    add(0, 6'h08, 0, 0, W_FETCH,    "fetch_stall");
    add(0, 6'h08, 0, 1, W_FETCH_GO, "addi_fetch");
    add(0, 6'h08, 0, 1, W_DECODE,   "addi_decode");
    add(0, 6'h08, 0, 1, W_MEMADR,   "addi_ex");
    add(0, 6'h08, 0, 1, W_ADDIWB,   "addi_wb");
    add(0, 6'h3F, 0, 1, W_FETCH_GO, "ill_fetch");
    add(0, 6'h3F, 0, 1, W_DECODE | DONE, "ill_decode");
    add(0, 6'h08, 0, 1, W_FETCH_GO | ILL, "ill_sticky_fetch");
    add(0, 6'h08, 0, 1, W_DECODE | ILL,   "ill_sticky_decode");
    add(0, 6'h08, 0, 1, W_MEMADR | ILL,   "ill_sticky_addiex");
    add(0, 6'h08, 0, 1, W_ADDIWB | ILL,   "ill_sticky_addiwb");
    add(0, 6'h05, 0, 1, W_FETCH_GO | ILL, "bne_fetch");
`ifdef BNE_EN
    add(0, 6'h05, 0, 1, W_DECODE | ILL,         "bne_decode");
    add(0, 6'h05, 0, 1, W_BRANCH | PCE | ILL,   "bne_taken");
`else
    add(0, 6'h05, 0, 1, W_DECODE | DONE | ILL,  "bne_illegal_decode");
    add(0, 6'h05, 0, 1, W_FETCH_GO | ILL,       "bne_illegal_fetch");
`endif
    add(1, 6'h05, 0, 1, W_FETCH_GO, "rst_clears_illegal");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr);
      sb.push_back(vecs[i].exp);
      #2 chk(vecs[i].name, observed(), sb.pop_front());
    end

    // Reset asserted mid-MEMWR: immediate FETCH, no write, no done pulse.
    @(negedge clk); drive(1'b0, 6'h2B, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 6'h2B, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 6'h2B, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 6'h2B, 1'b0, 1'b0);
    #2 chk("abort_in_memwr", observed(), W_MEMWR);
    #1 rst = 1'b1;
    #1 chk("abort_async_fetch", observed(), W_FETCH);
    @(negedge clk); drive(1'b0, 6'h2B, 1'b0, 1'b0);
    #2 chk("abort_next_cycle", observed(), W_FETCH);

    measure(6'h00, 4, "rtype");
    measure(6'h08, 4, "addi");
    measure(6'h23, 5, "lw");
    measure(6'h2B, 4, "sw");
    measure(6'h04, 3, "beq");
    measure(6'h02, 3, "j");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
